// File: rtl/led_pwm_driver.sv
// ---------------------------------------------------------------------------
// led_pwm_driver
//
// Drives the LED pins of the Whack-A-Mole board from the processor's packed
// led_commands bus. Each LED has a DUTY_W-bit duty value. New values land in
// a shadow bank and are copied into the active bank only when the PWM frame
// wraps, so an LED never changes brightness part-way through a frame.
//
// Frame: pwm_cnt steps 0 .. 2^DUTY_W-2 (255 counts for DUTY_W=8), one step
// per tick. A tick happens every PRESCALE clock cycles. An LED with duty d is
// high for exactly d counts per frame (0 = dark, 255 = always on).
//
// Ports
//   clock          in   system clock, all state on the rising edge
//   reset          in   asynchronous, active-low reset
//   enable         in   1 = PWM running; 0 = pins dark, counters held at 0
//   led_commands   in   NUM_LEDS*DUTY_W, duty for LED i at [DUTY_W*i +: DUTY_W]
//   commands_valid in   one-cycle strobe, capture led_commands into shadow
//   led_pins       out  NUM_LEDS registered PWM outputs
//   frame_done     out  one-cycle pulse in the cycle after each frame wrap
//   update_pending out  shadow bank holds values not yet applied
// ---------------------------------------------------------------------------
module led_pwm_driver #(
  parameter int NUM_LEDS = 18,
  parameter int DUTY_W   = 8,
  parameter int PRESCALE = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUM_LEDS*DUTY_W-1:0]   led_commands,
  input  logic                         commands_valid,
  output logic [NUM_LEDS-1:0]          led_pins,
  output logic                         frame_done,
  output logic                         update_pending
);

  // Last count of a frame: 2^DUTY_W - 2, giving a period of 2^DUTY_W - 1
  // counts so that duty 2^DUTY_W - 1 means "on for the whole frame".
  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'((1 << DUTY_W) - 2);

  // A one-cycle prescaler still needs a 1-bit register to keep the code
  // uniform; it simply never leaves 0 and tick is then asserted every cycle.
  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]                 prescaler;
  logic [DUTY_W-1:0]               pwm_cnt;
  logic                            tick;
  logic                            wrap;
  logic [NUM_LEDS-1:0][DUTY_W-1:0] shadow_bank;
  logic [NUM_LEDS-1:0][DUTY_W-1:0] active_bank;
  logic [NUM_LEDS-1:0]             pin_next;

  assign tick = enable && (prescaler == PS_LAST);
  assign wrap = tick && (pwm_cnt == CNT_LAST);

  // -------------------------------------------------------------------------
  // Frame timing. Dropping enable parks both counters at 0 so that a
  // re-enable always starts a fresh, full-length frame.
  // -------------------------------------------------------------------------
  // NOTE: clocked state is written with non-blocking assignments only, so
  // every register samples pre-edge values and the block order is irrelevant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
    end else if (!enable) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (wrap) begin
        pwm_cnt <= '0;
      end else if (tick) begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Shadow / active banks.
  //   - A strobe always overwrites the shadow (last write in a frame wins),
  //     whether or not the PWM is running.
  //   - On wrap a pending shadow is copied to active. The copy uses the
  //     pre-edge shadow, so a strobe landing in the wrap cycle is kept for
  //     the following wrap and leaves update_pending set.
  // -------------------------------------------------------------------------
  // NOTE: the banks are plain registers rather than a RAM, so they take the
  // asynchronous reset like the rest of the state; that is what makes a reset
  // throw away an update that was still pending.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shadow_bank    <= '0;
      active_bank    <= '0;
      update_pending <= 1'b0;
    end else begin
      if (wrap && update_pending) begin
        active_bank <= shadow_bank;
      end
      if (commands_valid) begin
        shadow_bank    <= led_commands;
        update_pending <= 1'b1;
      end else if (wrap) begin
        update_pending <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Per-LED compare. Strict less-than gives exactly d high counts per frame.
  // -------------------------------------------------------------------------
  // NOTE: pin_next gets a full default before the loop, so no path through
  // this combinational block leaves it unassigned and no latch is inferred.
  always_comb begin
    pin_next = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      pin_next[i] = enable && (pwm_cnt < active_bank[i]);
    end
  end

  // Registered outputs: pins lag pwm_cnt/active by one cycle, frame_done is
  // high for the single cycle after the wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      led_pins   <= '0;
      frame_done <= 1'b0;
    end else begin
      led_pins   <= pin_next;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// ---------------------------------------------------------------------------
// Self-checking bench for led_pwm_driver.
//
// The reference model tracks, per clock edge, where the bench believes the
// frame is (phase = current count, 0..254) and the shadow/active/pending
// state as the rules describe them. Pin behaviour is checked at frame level:
// the number of cycles each pin is high across one full frame must equal the
// duty the model says is active for that frame.
//
// A second instance with PRESCALE=4 checks the prescaled frame period.
// ---------------------------------------------------------------------------
module tb_led_pwm_driver;

  localparam int NUM_LEDS  = 18;
  localparam int DUTY_W    = 8;
  localparam int CMD_W     = NUM_LEDS * DUTY_W;
  localparam int FRAME     = 255;
  localparam int PRESCALE4 = 4;

  logic                clock = 1'b0;
  logic                reset = 1'b1;

  logic                enable         = 1'b0;
  logic                commands_valid = 1'b0;
  logic [CMD_W-1:0]    led_commands   = '0;
  logic [NUM_LEDS-1:0] led_pins;
  logic                frame_done;
  logic                update_pending;

  logic                enable4         = 1'b0;
  logic                commands_valid4 = 1'b0;
  logic [CMD_W-1:0]    led_commands4   = '0;
  logic [NUM_LEDS-1:0] led_pins4;
  logic                frame_done4;
  logic                update_pending4;

  always #5 clock = ~clock;

  led_pwm_driver #(.NUM_LEDS(NUM_LEDS), .DUTY_W(DUTY_W), .PRESCALE(1)) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .led_commands   (led_commands),
    .commands_valid (commands_valid),
    .led_pins       (led_pins),
    .frame_done     (frame_done),
    .update_pending (update_pending)
  );

  led_pwm_driver #(.NUM_LEDS(NUM_LEDS), .DUTY_W(DUTY_W), .PRESCALE(PRESCALE4)) dut4 (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable4),
    .led_commands   (led_commands4),
    .commands_valid (commands_valid4),
    .led_pins       (led_pins4),
    .frame_done     (frame_done4),
    .update_pending (update_pending4)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  int         phase = 0;
  logic [7:0] m_shadow [NUM_LEDS];
  logic [7:0] m_active [NUM_LEDS];
  bit         m_pending = 1'b0;

  // Last frame measurement.
  int         meas_highs [NUM_LEDS];
  logic [7:0] meas_exp   [NUM_LEDS];
  int         meas_fd;

  function automatic logic [CMD_W-1:0] rand_cmd();
    logic [CMD_W-1:0] v;
    for (int i = 0; i < NUM_LEDS; i++) v[8*i +: 8] = 8'($urandom);
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_LEDS; i++) begin
      m_shadow[i] = 8'h00;
      m_active[i] = 8'h00;
    end
    m_pending = 1'b0;
    phase     = 0;
  endtask

  // Advance one clock; update the model with the inputs seen at that edge,
  // then settle 1 time unit after the edge (sampling and driving point).
  task automatic cyc();
    @(posedge clock);
    if (reset) begin
      if (enable && phase == FRAME-1 && m_pending) begin
        m_active  = m_shadow;
        m_pending = 1'b0;
      end
      if (commands_valid) begin
        for (int i = 0; i < NUM_LEDS; i++) m_shadow[i] = led_commands[8*i +: 8];
        m_pending = 1'b1;
      end
      phase = enable ? (phase + 1) % FRAME : 0;
    end else begin
      phase = 0;
    end
    #1;
  endtask

  task automatic strobe(input logic [CMD_W-1:0] cmd);
    led_commands   = cmd;
    commands_valid = 1'b1;
    cyc();
    commands_valid = 1'b0;
  endtask

  task automatic sync_to(input int p);
    for (int i = 0; i < 2*FRAME && phase != p; i++) cyc();
  endtask

  // Pins at phase 1..254,0 reflect counts 0..254 of one frame.
  task automatic measure_frame();
    sync_to(1);
    meas_exp = m_active;
    for (int i = 0; i < NUM_LEDS; i++) meas_highs[i] = 0;
    meas_fd = 0;
    for (int c = 0; c < FRAME; c++) begin
      for (int i = 0; i < NUM_LEDS; i++) meas_highs[i] += int'(led_pins[i]);
      meas_fd += int'(frame_done);
      cyc();
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    #2 reset = 1'b0;
    model_clear();
    #1;
    n_vec++; if (led_pins !== '0) begin n_err++; $display("FAIL reset_pins: got %h, want 0", led_pins); end
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %b, want 0", frame_done); end
    n_vec++; if (update_pending !== 1'b0) begin n_err++; $display("FAIL reset_pending: got %b, want 0", update_pending); end
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    n_vec++; if (led_pins !== '0) begin n_err++; $display("FAIL post_reset_pins: got %h, want 0", led_pins); end
    n_vec++; if (update_pending !== 1'b0) begin n_err++; $display("FAIL post_reset_pending: got %b, want 0", update_pending); end
  endtask

  task automatic test_basic_duty();
    logic [CMD_W-1:0] cmd;
    enable = 1'b1;
    cmd = rand_cmd();
    cmd[7:0]   = 8'h80;
    cmd[15:8]  = 8'h00;
    cmd[23:16] = 8'hFF;
    strobe(cmd);
    n_vec++; if (update_pending !== 1'b1) begin n_err++; $display("FAIL basic_pending_set: got %b, want 1", update_pending); end
    sync_to(FRAME-1);
    n_vec++; if (update_pending !== 1'b1) begin n_err++; $display("FAIL basic_pending_hold: got %b, want 1", update_pending); end
    cyc();
    n_vec++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL basic_frame_done: got %b, want 1", frame_done); end
    n_vec++; if (update_pending !== 1'b0) begin n_err++; $display("FAIL basic_pending_clear: got %b, want 0", update_pending); end
    measure_frame();
    for (int i = 0; i < NUM_LEDS; i++) begin
      n_vec++;
      if (meas_highs[i] !== int'(meas_exp[i])) begin
        n_err++; $display("FAIL basic_duty led%0d: high %0d cycles, want %0d", i, meas_highs[i], meas_exp[i]);
      end
    end
    n_vec++; if (meas_highs[0] !== 128) begin n_err++; $display("FAIL basic_led0: high %0d, want 128", meas_highs[0]); end
    n_vec++; if (meas_highs[1] !== 0)   begin n_err++; $display("FAIL basic_led1: high %0d, want 0", meas_highs[1]); end
    n_vec++; if (meas_highs[2] !== 255) begin n_err++; $display("FAIL basic_led2: high %0d, want 255", meas_highs[2]); end
    n_vec++; if (meas_fd !== 1) begin n_err++; $display("FAIL basic_fd_per_frame: got %0d, want 1", meas_fd); end
  endtask

  task automatic test_last_write();
    logic [CMD_W-1:0] cmd;
    sync_to(10);
    cmd = rand_cmd(); cmd[47:40] = 8'h10; strobe(cmd);
    sync_to(50);
    cmd = rand_cmd(); cmd[47:40] = 8'h40; strobe(cmd);
    measure_frame();
    for (int i = 0; i < NUM_LEDS; i++) begin
      n_vec++;
      if (meas_highs[i] !== int'(meas_exp[i])) begin
        n_err++; $display("FAIL last_write led%0d: high %0d cycles, want %0d", i, meas_highs[i], meas_exp[i]);
      end
    end
    n_vec++; if (meas_highs[5] !== 64) begin n_err++; $display("FAIL last_write_led5: high %0d, want 64", meas_highs[5]); end
  endtask

  task automatic test_strobe_on_wrap();
    logic [CMD_W-1:0] cmd;
    sync_to(20);
    cmd = rand_cmd(); cmd[31:24] = 8'h20; strobe(cmd);
    sync_to(FRAME-1);
    cmd = rand_cmd(); cmd[31:24] = 8'h60; strobe(cmd);
    n_vec++; if (update_pending !== 1'b1) begin n_err++; $display("FAIL wrap_strobe_pending: got %b, want 1", update_pending); end
    measure_frame();
    for (int i = 0; i < NUM_LEDS; i++) begin
      n_vec++;
      if (meas_highs[i] !== int'(meas_exp[i])) begin
        n_err++; $display("FAIL wrap_frame1 led%0d: high %0d cycles, want %0d", i, meas_highs[i], meas_exp[i]);
      end
    end
    n_vec++; if (meas_highs[3] !== 32) begin n_err++; $display("FAIL wrap_led3_first: high %0d, want 32", meas_highs[3]); end
    n_vec++; if (update_pending !== 1'b0) begin n_err++; $display("FAIL wrap_pending_clear: got %b, want 0", update_pending); end
    measure_frame();
    for (int i = 0; i < NUM_LEDS; i++) begin
      n_vec++;
      if (meas_highs[i] !== int'(meas_exp[i])) begin
        n_err++; $display("FAIL wrap_frame2 led%0d: high %0d cycles, want %0d", i, meas_highs[i], meas_exp[i]);
      end
    end
    n_vec++; if (meas_highs[3] !== 96) begin n_err++; $display("FAIL wrap_led3_second: high %0d, want 96", meas_highs[3]); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int c = 0; c < FRAME; c++) begin
        commands_valid = ($urandom_range(0, 40) == 0) || (it == 2 && phase == FRAME-1);
        led_commands   = rand_cmd();
        cyc();
      end
      commands_valid = 1'b0;
      n_vec++;
      if (update_pending !== m_pending) begin
        n_err++; $display("FAIL random_pending it%0d: got %b, want %b", it, update_pending, m_pending);
      end
      measure_frame();
      for (int i = 0; i < NUM_LEDS; i++) begin
        n_vec++;
        if (meas_highs[i] !== int'(meas_exp[i])) begin
          n_err++; $display("FAIL random it%0d led%0d: high %0d cycles, want %0d", it, i, meas_highs[i], meas_exp[i]);
        end
      end
      n_vec++; if (meas_fd !== 1) begin n_err++; $display("FAIL random_fd it%0d: got %0d, want 1", it, meas_fd); end
    end
  endtask

  task automatic test_enable();
    logic [CMD_W-1:0]    cmd;
    logic [NUM_LEDS-1:0] exp_pins;
    int fd_cnt, pin_cnt, n;
    sync_to(1);
    for (int i = 0; i < NUM_LEDS; i++) cmd[8*i +: 8] = 8'($urandom_range(128, 255));
    strobe(cmd);
    sync_to(1);
    sync_to(100);
    for (int i = 0; i < NUM_LEDS; i++) exp_pins[i] = (99 < int'(m_active[i]));
    n_vec++; if (led_pins !== exp_pins) begin n_err++; $display("FAIL enable_pre_pins: got %h, want %h", led_pins, exp_pins); end
    enable = 1'b0;
    cyc();
    n_vec++; if (led_pins !== '0) begin n_err++; $display("FAIL enable_off_pins: got %h, want 0", led_pins); end
    fd_cnt = 0; pin_cnt = 0;
    for (int c = 0; c < 1000; c++) begin
      fd_cnt  += int'(frame_done);
      pin_cnt += $countones(led_pins);
      cyc();
    end
    n_vec++; if (fd_cnt !== 0) begin n_err++; $display("FAIL enable_off_frame_done: got %0d pulses, want 0", fd_cnt); end
    n_vec++; if (pin_cnt !== 0) begin n_err++; $display("FAIL enable_off_dark: got %0d high samples, want 0", pin_cnt); end
    enable = 1'b1;
    n = 0;
    while (n < 400) begin
      cyc(); n++;
      if (frame_done === 1'b1) break;
    end
    n_vec++; if (n !== FRAME) begin n_err++; $display("FAIL reenable_first_frame_done: after %0d cycles, want %0d", n, FRAME); end
    measure_frame();
    for (int i = 0; i < NUM_LEDS; i++) begin
      n_vec++;
      if (meas_highs[i] !== int'(meas_exp[i])) begin
        n_err++; $display("FAIL reenable led%0d: high %0d cycles, want %0d", i, meas_highs[i], meas_exp[i]);
      end
    end
  endtask

  task automatic test_prescale();
    int n, highs, rises;
    logic prev;
    led_commands4       = '0;
    led_commands4[7:0]  = 8'h01;
    commands_valid4     = 1'b1;
    cyc();
    commands_valid4     = 1'b0;
    n_vec++; if (update_pending4 !== 1'b1) begin n_err++; $display("FAIL ps_pending_set: got %b, want 1", update_pending4); end
    enable4 = 1'b1;
    n = 0;
    while (n < 1200) begin
      cyc(); n++;
      if (frame_done4 === 1'b1) break;
    end
    n_vec++; if (n !== FRAME*PRESCALE4) begin n_err++; $display("FAIL ps_first_frame: after %0d cycles, want %0d", n, FRAME*PRESCALE4); end
    n_vec++; if (update_pending4 !== 1'b0) begin n_err++; $display("FAIL ps_pending_clear: got %b, want 0", update_pending4); end
    n = 0; highs = 0; rises = 0; prev = led_pins4[0];
    while (n < 1200) begin
      cyc(); n++;
      highs += int'(led_pins4[0]);
      if (led_pins4[0] && !prev) rises++;
      prev = led_pins4[0];
      if (frame_done4 === 1'b1) break;
    end
    n_vec++; if (n !== FRAME*PRESCALE4) begin n_err++; $display("FAIL ps_period: got %0d cycles, want %0d", n, FRAME*PRESCALE4); end
    n_vec++; if (highs !== PRESCALE4) begin n_err++; $display("FAIL ps_led0_high: got %0d cycles, want %0d", highs, PRESCALE4); end
    n_vec++; if (rises !== 1) begin n_err++; $display("FAIL ps_led0_contiguous: got %0d high runs, want 1", rises); end
  endtask

  task automatic test_reset_midframe();
    logic [CMD_W-1:0] cmd;
    sync_to(1);
    cmd = rand_cmd(); cmd[7:0] = 8'h80; strobe(cmd);
    sync_to(1);
    sync_to(100);
    n_vec++;
    if (led_pins[0] !== (99 < int'(m_active[0]))) begin
      n_err++; $display("FAIL rst_pre_led0: got %b, want %b", led_pins[0], (99 < int'(m_active[0])));
    end
    strobe(rand_cmd());
    n_vec++; if (update_pending !== 1'b1) begin n_err++; $display("FAIL rst_pre_pending: got %b, want 1", update_pending); end
    #2 reset = 1'b0;
    model_clear();
    #1;
    n_vec++; if (led_pins !== '0) begin n_err++; $display("FAIL rst_mid_pins: got %h, want 0", led_pins); end
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_mid_frame_done: got %b, want 0", frame_done); end
    n_vec++; if (update_pending !== 1'b0) begin n_err++; $display("FAIL rst_mid_pending: got %b, want 0", update_pending); end
    repeat (2) cyc();
    reset = 1'b1;
    measure_frame();
    for (int i = 0; i < NUM_LEDS; i++) begin
      n_vec++;
      if (meas_highs[i] !== int'(meas_exp[i])) begin
        n_err++; $display("FAIL rst_after led%0d: high %0d cycles, want %0d", i, meas_highs[i], meas_exp[i]);
      end
    end
    n_vec++; if (meas_highs[0] !== 0) begin n_err++; $display("FAIL rst_led0_dark: high %0d, want 0", meas_highs[0]); end
    n_vec++; if (update_pending !== 1'b0) begin n_err++; $display("FAIL rst_after_pending: got %b, want 0", update_pending); end
  endtask

  initial begin
    test_reset();
    test_basic_duty();
    test_last_write();
    test_strobe_on_wrap();
    test_random();
    test_enable();
    test_prescale();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete within 2 ms");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/led_pwm_driver.md
Name: led_pwm_driver

Overview:
- Sits directly downstream of the processor's 144-bit led_commands bus and drives the 18 physical LED pins of the Whack-A-Mole board.
- Each LED gets an 8-bit duty value from led_commands.
- New values are captured into a shadow bank and applied only at a PWM frame boundary, so brightness never glitches mid-frame.
- Generates a per-LED PWM waveform and a frame-boundary pulse that software or bench logic uses for timing.

Parameters:
- NUM_LEDS, 18, number of LED channels; led_commands width = NUM_LEDS*DUTY_W.
- DUTY_W, 8, duty bits per LED; PWM period = 2^DUTY_W - 1 ticks.
- PRESCALE, 1, clock cycles per PWM tick (>=1).

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  1 = PWM running; 0 = outputs dark, counters held at 0.
- led_commands  input  144  duty for LED i in bits [8*i+7:8*i].
- commands_valid  input  1  single-cycle strobe; capture led_commands into shadow bank.
- led_pins  output  18  PWM outputs, registered.
- frame_done  output  1  one-cycle pulse after each PWM frame wrap.
- update_pending  output  1  shadow bank holds values not yet applied.

Behaviour:
- Reset (reset=0, asynchronous):
  - led_pins=0, frame_done=0, update_pending=0.
  - Prescaler, pwm_cnt, shadow bank and active bank all 0.
  - Reset asserted mid-frame discards any pending update.
- Prescaler:
  - Counts 0..PRESCALE-1 while enable=1.
  - tick=1 in the cycle where prescaler==PRESCALE-1, then the prescaler returns to 0.
  - With PRESCALE=1, tick is asserted every cycle.
- pwm_cnt:
  - DUTY_W bits; advances on tick through 0..254 and wraps 254->0.
  - wrap = tick && pwm_cnt==254.
- Capture:
  - commands_valid=1 -> shadow <= led_commands and update_pending <= 1 next edge.
  - Later strobes in the same frame overwrite shadow (last write wins).
  - Capture is accepted regardless of enable.
- Apply:
  - On wrap with update_pending=1: active <= shadow (pre-edge value); update_pending <= 0 unless commands_valid is also 1 that cycle.
- Simultaneous wrap and commands_valid:
  - active takes the old shadow (if pending).
  - shadow takes the new led_commands.
  - update_pending=1 afterwards.
  - The new value is applied at the following wrap.
- Output:
  - led_pins[i] <= enable && (pwm_cnt < active[i]), one cycle of latency from pwm_cnt/active.
  - duty 0 -> never high; duty 255 -> high for all 255 counts; duty d -> high for exactly d ticks per frame.
- frame_done:
  - Registered pulse, high for exactly one cycle in the cycle after wrap.
  - Period = 255*PRESCALE cycles.
- enable=0:
  - Prescaler and pwm_cnt are forced to 0 synchronously; led_pins=0 the next cycle.
  - No wrap occurs, so no frame_done and no apply; active holds its value.
  - Re-enable restarts the frame from pwm_cnt=0, prescaler=0.
- No other handshake: commands_valid is never back-pressured.

Test Plan:
- Reset: run with LED0 duty 0x80 applied, drive reset=0 at pwm_cnt=100 -> led_pins=0, frame_done=0, update_pending=0 immediately (before next clock edge); after release, LED0 stays dark (active=0).
- Basic duty: PRESCALE=1, LED0=0x80, LED1=0x00, LED2=0xFF, strobe commands_valid -> update_pending=1 until first wrap. In the next full frame: led_pins[0] high 128 of 255 cycles, led_pins[1] never high, led_pins[2] high all 255.
- Last write wins: two strobes in one frame (LED5=0x10, then 0x40) -> at wrap active[5]=0x40; next frame led_pins[5] high exactly 64 cycles.
- Strobe on wrap cycle: pending LED3=0x20 plus a new strobe with LED3=0x60 in the wrap cycle -> next frame LED3 high 32 cycles, update_pending stays 1; the frame after that shows 96 cycles, then update_pending=0.
- Enable gating: enable=0 mid-frame -> led_pins=0 one cycle later, no frame_done for 1000 cycles. Re-enable -> first frame_done exactly 255 cycles after enable rises (PRESCALE=1).
- Prescale: PRESCALE=4, LED0=0x01 -> frame_done period 1020 cycles; led_pins[0] high exactly 4 consecutive cycles per frame.
